// File: rtl/sa_drv_pkg.sv
// Shared types and constants for the 3x3 systolic-array feeder.
// Holds the driver state enum, the array size and the w_flat indexing helper.
package sa_drv_pkg;

    localparam int SA_N       = 3;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    // Bit offset of weight w[r][c] inside the row-major w_flat bus.
    function automatic int w_lsb(input logic [1:0] r, input logic [1:0] c, input int dw);
        return (int'(r) * SA_N + int'(c)) * dw;
    endfunction

endpackage

// File: rtl/sa_3x3_driver_if.sv
// Controller handshake, activation/result streams and array-side lanes of the 3x3 feeder.
// The reuse_w signal exists only when SA_DRV_REUSE_W_EN is defined.
interface sa_3x3_driver_if #(
    parameter int DATA_W    = 8,
    parameter int MAX_VEC_W = 8
);
    logic                   start;
    logic [MAX_VEC_W-1:0]   num_vec;
    logic [9*DATA_W-1:0]    w_flat;
`ifdef SA_DRV_REUSE_W_EN
    logic                   reuse_w;
`endif
    logic                   act_valid;
    logic                   act_ready;
    logic [3*DATA_W-1:0]    act_data;
    logic [DATA_W-1:0]      sa_a1, sa_a2, sa_a3;
    logic [DATA_W-1:0]      sa_b1, sa_b2, sa_b3;
    logic                   sa_p1_en;
    logic [DATA_W-1:0]      sa_c;
    logic                   res_valid;
    logic [DATA_W-1:0]      res_data;
    logic                   busy;
    logic                   done;

    modport master (
`ifdef SA_DRV_REUSE_W_EN
        output reuse_w,
`endif
        output start, num_vec, w_flat, act_valid, act_data, sa_c,
        input  act_ready, sa_a1, sa_a2, sa_a3, sa_b1, sa_b2, sa_b3, sa_p1_en,
        input  res_valid, res_data, busy, done
    );

    modport slave (
`ifdef SA_DRV_REUSE_W_EN
        input  reuse_w,
`endif
        input  start, num_vec, w_flat, act_valid, act_data, sa_c,
        output act_ready, sa_a1, sa_a2, sa_a3, sa_b1, sa_b2, sa_b3, sa_p1_en,
        output res_valid, res_data, busy, done
    );

endinterface

// File: rtl/sa_drv_skew.sv
// One-lane delay line of DEPTH registers with asynchronous clear.
// any_o reports whether any stage still holds a nonzero value.
module sa_drv_skew #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o,
    output logic              any_o
);

    logic [DATA_W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

    always_comb begin
        any_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_o = any_o | (|stage_q[i]);
    end

endmodule

// File: rtl/sa_3x3_driver.sv
// Feeder for the 3x3 systolic array: weight preload, skewed activation stream, result capture.
// Defining SA_DRV_REUSE_W_EN adds reuse_w, which skips the preload and keeps the array weights.
module sa_3x3_driver
    import sa_drv_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RES_LAT   = 5,
    parameter int MAX_VEC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    sa_3x3_driver_if.slave  bus
);

    state_e                 state_q, state_d;
    logic [1:0]             load_cnt_q, load_cnt_d;
    logic [MAX_VEC_W-1:0]   num_q, num_d;
    logic [MAX_VEC_W-1:0]   cnt_q, cnt_d;
    logic [9*DATA_W-1:0]    w_q, w_d;
    logic                   res_valid_q;
    logic [DATA_W-1:0]      res_data_q;

    logic                   xfer;
    logic                   act_ready;
    logic                   p1_en;
    logic [DATA_W-1:0]      b1, b2, b3;
    logic [DATA_W-1:0]      lane_in  [SA_N];
    logic [DATA_W-1:0]      lane_out [SA_N];
    logic [SA_N-1:0]        lane_any;
    logic                   tag_out;
    logic                   tag_any;

    // Lane n carries n+1 registers so consecutive vectors land on the array diagonal.
    for (genvar n = 0; n < SA_N; n++) begin : g_lane
        assign lane_in[n] = xfer ? bus.act_data[n*DATA_W +: DATA_W] : '0;
        sa_drv_skew #(.DEPTH(n + 1), .DATA_W(DATA_W)) u_skew (
            .clk   (clk),
            .rst   (rst),
            .d_i   (lane_in[n]),
            .q_o   (lane_out[n]),
            .any_o (lane_any[n])
        );
    end

    sa_drv_skew #(.DEPTH(RES_LAT), .DATA_W(1)) u_tag (
        .clk   (clk),
        .rst   (rst),
        .d_i   (xfer),
        .q_o   (tag_out),
        .any_o (tag_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            w_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            w_q         <= w_d;
            res_valid_q <= tag_out;
            if (tag_out) res_data_q <= bus.sa_c;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        xfer       = 1'b0;
        act_ready  = 1'b0;
        p1_en      = 1'b0;
        b1         = '0;
        b2         = '0;
        b3         = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    num_d      = bus.num_vec;
                    cnt_d      = '0;
                    load_cnt_d = '0;
`ifdef SA_DRV_REUSE_W_EN
                    if (bus.reuse_w) begin
                        state_d = (bus.num_vec == '0) ? DRAIN : STREAM;
                    end else begin
                        w_d     = bus.w_flat;
                        state_d = LOAD;
                    end
`else
                    w_d     = bus.w_flat;
                    state_d = LOAD;
`endif
                end
            end
            LOAD: begin
                p1_en = 1'b1;
                b1    = w_q[w_lsb(load_cnt_q, 2'd0, DATA_W) +: DATA_W];
                b2    = w_q[w_lsb(load_cnt_q, 2'd1, DATA_W) +: DATA_W];
                b3    = w_q[w_lsb(load_cnt_q, 2'd2, DATA_W) +: DATA_W];
                if (load_cnt_q == 2'd2) begin
                    state_d = (num_q == '0) ? DRAIN : STREAM;
                end else begin
                    load_cnt_d = load_cnt_q + 2'd1;
                end
            end
            STREAM: begin
                act_ready = (cnt_q != num_q);
                xfer      = act_ready && bus.act_valid;
                if (xfer) begin
                    cnt_d = cnt_q + MAX_VEC_W'(1);
                    if (cnt_q == num_q - MAX_VEC_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Zero columns keep flowing until the last tag has produced its result.
                if (!tag_any && (lane_any == '0)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.act_ready = act_ready;
    assign bus.sa_a1     = lane_out[0];
    assign bus.sa_a2     = lane_out[1];
    assign bus.sa_a3     = lane_out[2];
    assign bus.sa_b1     = b1;
    assign bus.sa_b2     = b2;
    assign bus.sa_b3     = b3;
    assign bus.sa_p1_en  = p1_en;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_sa_3x3_driver.sv
// Directed bench for sa_3x3_driver: a cycle table for preload and single-vector skew, plus
// generated sequences for streaming, bubbles, num_vec=0, reset and SA_DRV_REUSE_W_EN reuse.
`timescale 1ns/1ps
module tb_sa_3x3_driver;

    localparam int DATA_W    = 8;
    localparam int RES_LAT   = 5;
    localparam int MAX_VEC_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sa_3x3_driver_if #(.DATA_W(DATA_W), .MAX_VEC_W(MAX_VEC_W)) bus ();

    sa_3x3_driver #(.DATA_W(DATA_W), .RES_LAT(RES_LAT), .MAX_VEC_W(MAX_VEC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        av;
        logic [23:0] ad;
        logic [7:0]  sc;
        logic        p1;
        logic [23:0] b;
        logic [23:0] a;
        logic        rdy;
        logic        bsy;
        logic        dn;
        logic        rv;
        logic [7:0]  rd;
    } row_t;

    row_t tbl [14];

    function automatic row_t mk(input logic start, input logic av, input logic [23:0] ad,
                                input logic [7:0] sc, input logic p1, input logic [23:0] b,
                                input logic [23:0] a, input logic rdy, input logic bsy,
                                input logic dn, input logic rv, input logic [7:0] rd);
        row_t r;
        r.start = start; r.av = av; r.ad = ad; r.sc = sc; r.p1 = p1; r.b = b; r.a = a;
        r.rdy = rdy; r.bsy = bsy; r.dn = dn; r.rv = rv; r.rd = rd;
        return r;
    endfunction

    function automatic logic [23:0] vecData(input int k);
        return {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic av, input logic [23:0] ad, input logic [7:0] sc);
        bus.start     = start;
        bus.act_valid = av;
        bus.act_data  = ad;
        bus.sa_c      = sc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " sa_p1_en"}, 32'(bus.sa_p1_en), 32'd0);
        checkOutput({tag, " sa_b"}, 32'({bus.sa_b3, bus.sa_b2, bus.sa_b1}), 32'd0);
        checkOutput({tag, " sa_a"}, 32'({bus.sa_a3, bus.sa_a2, bus.sa_a1}), 32'd0);
        checkOutput({tag, " act_ready"}, 32'(bus.act_ready), 32'd0);
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " res_valid"}, 32'(bus.res_valid), 32'd0);
        checkOutput({tag, " res_data"}, 32'(bus.res_data), 32'd0);
    endtask

    // Starts a run at c=0 (plus an ignored start in LOAD) and checks every cycle against
    // transfer times derived from the act_valid pattern.
    task automatic runSeq(input string tag, input int num, input logic [15:0] pat);
        int          xc [8];
        int          nx;
        int          doneC;
        int          rvCount;
        int          idx;
        logic [23:0] ea;
        logic [23:0] tmp;
        logic        rvE;
        nx      = 0;
        rvCount = 0;
        for (int c = 4; c < 20; c++) begin
            if (pat[c-4] && nx < num) begin
                xc[nx] = c;
                nx++;
            end
        end
        doneC = (num == 0) ? 5 : xc[num-1] + RES_LAT + 2;
        bus.num_vec = MAX_VEC_W'(num);
        bus.w_flat  = 72'h1122334455667788AA;
        for (int c = 0; c < doneC + 3; c++) begin
            idx = 0;
            for (int k = 0; k < nx; k++) if (xc[k] < c) idx++;
            applyStimulus((c == 0) || (c == 2), (c >= 4 && c < 20) ? pat[c-4] : 1'b0,
                          vecData(idx), 8'(8'h80 + c));
            #1;
            ea  = '0;
            rvE = 1'b0;
            for (int k = 0; k < nx; k++) begin
                tmp = vecData(k);
                for (int n = 0; n < 3; n++) if (c == xc[k] + n + 1) ea[n*8 +: 8] = tmp[n*8 +: 8];
                if (c == xc[k] + RES_LAT + 1) rvE = 1'b1;
            end
            checkOutput({tag, " act_ready"}, 32'(bus.act_ready), 32'(nx > 0 && c >= 4 && c <= xc[nx-1]));
            checkOutput({tag, " sa_a"}, 32'({bus.sa_a3, bus.sa_a2, bus.sa_a1}), 32'(ea));
            checkOutput({tag, " sa_p1_en"}, 32'(bus.sa_p1_en), 32'(c >= 1 && c <= 3));
            checkOutput({tag, " busy"}, 32'(bus.busy), 32'(c >= 1 && c <= doneC));
            checkOutput({tag, " done"}, 32'(bus.done), 32'(c == doneC));
            checkOutput({tag, " res_valid"}, 32'(bus.res_valid), 32'(rvE));
            if (rvE) checkOutput({tag, " res_data"}, 32'(bus.res_data), 32'(8'(8'h80 + c - 1)));
            if (bus.res_valid) rvCount++;
            tick();
        end
        applyStimulus(1'b0, 1'b0, 24'd0, 8'd0);
        checkOutput({tag, " result count"}, 32'(rvCount), 32'(num));
    endtask

    task automatic resetMidStream();
        bus.num_vec = 8'd4;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(c == 0, c >= 4, 24'h332211, 8'h00);
            tick();
        end
        checkOutput("pre-reset sa_a1", 32'(bus.sa_a1), 32'h11);
        checkOutput("pre-reset busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1 checkAllZero("mid-stream reset");
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 24'h332211, 8'h00);
        for (int c = 0; c < 12; c++) begin
            checkOutput("post-reset done", 32'(bus.done), 32'd0);
            checkOutput("post-reset res_valid", 32'(bus.res_valid), 32'd0);
            checkOutput("post-reset busy", 32'(bus.busy), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 24'd0, 8'd0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 24'd0, 8'd0);
        bus.num_vec = '0;
        bus.w_flat  = '0;
`ifdef SA_DRV_REUSE_W_EN
        bus.reuse_w = 1'b0;
`endif
        tbl[0]  = mk(1, 0, 24'h0,      8'hEE, 0, 24'h0,      24'h0,      0, 0, 0, 0, 8'h0);
        tbl[1]  = mk(1, 1, 24'h999999, 8'hEE, 1, 24'h030201, 24'h0,      0, 1, 0, 0, 8'h0);
        tbl[2]  = mk(0, 0, 24'h0,      8'hEE, 1, 24'h060504, 24'h0,      0, 1, 0, 0, 8'h0);
        tbl[3]  = mk(0, 0, 24'h0,      8'hEE, 1, 24'h090807, 24'h0,      0, 1, 0, 0, 8'h0);
        tbl[4]  = mk(0, 1, 24'h030201, 8'hEE, 0, 24'h0,      24'h0,      1, 1, 0, 0, 8'h0);
        tbl[5]  = mk(0, 0, 24'h0,      8'hEE, 0, 24'h0,      24'h000001, 0, 1, 0, 0, 8'h0);
        tbl[6]  = mk(1, 0, 24'h0,      8'hEE, 0, 24'h0,      24'h000200, 0, 1, 0, 0, 8'h0);
        tbl[7]  = mk(0, 0, 24'h0,      8'hEE, 0, 24'h0,      24'h030000, 0, 1, 0, 0, 8'h0);
        tbl[8]  = mk(0, 0, 24'h0,      8'hEE, 0, 24'h0,      24'h0,      0, 1, 0, 0, 8'h0);
        tbl[9]  = mk(0, 0, 24'h0,      8'h77, 0, 24'h0,      24'h0,      0, 1, 0, 0, 8'h0);
        tbl[10] = mk(0, 0, 24'h0,      8'hEE, 0, 24'h0,      24'h0,      0, 1, 0, 1, 8'h77);
        tbl[11] = mk(0, 0, 24'h0,      8'hEE, 0, 24'h0,      24'h0,      0, 1, 1, 0, 8'h0);
        tbl[12] = mk(0, 0, 24'h0,      8'hEE, 0, 24'h0,      24'h0,      0, 0, 0, 0, 8'h0);
        tbl[13] = mk(0, 0, 24'h0,      8'hEE, 0, 24'h0,      24'h0,      0, 0, 0, 0, 8'h0);

        repeat (2) @(posedge clk);
        #1 checkAllZero("reset");
        rst = 1'b0;

        $display("[TB] preload and single-vector table");
        bus.num_vec = 8'd1;
        for (int i = 0; i < 9; i++) bus.w_flat[i*8 +: 8] = 8'(i + 1);
        for (int r = 0; r < 14; r++) begin
            applyStimulus(tbl[r].start, tbl[r].av, tbl[r].ad, tbl[r].sc);
            #1;
            checkOutput($sformatf("row%0d sa_p1_en", r), 32'(bus.sa_p1_en), 32'(tbl[r].p1));
            checkOutput($sformatf("row%0d sa_b", r), 32'({bus.sa_b3, bus.sa_b2, bus.sa_b1}), 32'(tbl[r].b));
            checkOutput($sformatf("row%0d sa_a", r), 32'({bus.sa_a3, bus.sa_a2, bus.sa_a1}), 32'(tbl[r].a));
            checkOutput($sformatf("row%0d act_ready", r), 32'(bus.act_ready), 32'(tbl[r].rdy));
            checkOutput($sformatf("row%0d busy", r), 32'(bus.busy), 32'(tbl[r].bsy));
            checkOutput($sformatf("row%0d done", r), 32'(bus.done), 32'(tbl[r].dn));
            checkOutput($sformatf("row%0d res_valid", r), 32'(bus.res_valid), 32'(tbl[r].rv));
            if (tbl[r].rv) checkOutput($sformatf("row%0d res_data", r), 32'(bus.res_data), 32'(tbl[r].rd));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 24'd0, 8'd0);

        $display("[TB] streaming sequences");
        runSeq("b2b", 4, 16'hFFFF);
        runSeq("bubble", 2, 16'h0005);
        runSeq("late", 1, 16'h0004);
        runSeq("zero", 0, 16'hFFFF);

        $display("[TB] reset during stream");
        resetMidStream();

`ifdef SA_DRV_REUSE_W_EN
        $display("[TB] weight reuse");
        bus.reuse_w = 1'b1;
        bus.num_vec = 8'd1;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(c == 0, c == 1, 24'h030201, 8'(8'h40 + c));
            #1;
            checkOutput("reuse sa_p1_en", 32'(bus.sa_p1_en), 32'd0);
            checkOutput("reuse act_ready", 32'(bus.act_ready), 32'(c == 1));
            checkOutput("reuse res_valid", 32'(bus.res_valid), 32'(c == 1 + RES_LAT + 1));
            checkOutput("reuse done", 32'(bus.done), 32'(c == 1 + RES_LAT + 2));
            if (c == 1 + RES_LAT + 1) checkOutput("reuse res_data", 32'(bus.res_data), 32'(8'(8'h40 + c - 1)));
            tick();
        end
        bus.reuse_w = 1'b0;
        applyStimulus(1'b0, 1'b0, 24'd0, 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_3x3_driver.md
Name: sa_3x3_driver

Overview:
- Initiator/feeder for the 3x3 systolic array (ports clk, rst, A_in_1..3, B_in_1..3, P1_en, C_out).
- Sequences the weight preload, streams diagonally skewed activation vectors, and captures the array's C_out into a result stream.
- Sits between the LCD compute controller (start/handshake side) and the SA_3x3 instance (array side).

Parameters:
- DATA_W, 8, width of every weight, activation and result element.
- RES_LAT, 5, cycles from a vector's lane-1 element on A_in_1 to its result valid on C_out (must be >= 3).
- MAX_VEC_W, 8, width of the vector-count field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_vec  in  MAX_VEC_W  number of activation vectors; latched on accepted start.
- w_flat  in  9*DATA_W  weights, row-major; w[r][c] at bits [(3r+c)*DATA_W +: DATA_W]; latched on accepted start.
- act_valid  in  1  activation vector valid.
- act_ready  out  1  driver accepts a vector this cycle.
- act_data  in  3*DATA_W  {a3, a2, a1}; a1 in the low byte.
- sa_a1, sa_a2, sa_a3  out  DATA_W each  to A_in_1..3.
- sa_b1, sa_b2, sa_b3  out  DATA_W each  to B_in_1..3.
- sa_p1_en  out  1  to P1_en (weight preload enable).
- sa_c  in  DATA_W  from C_out.
- res_valid  out  1  res_data holds a captured result.
- res_data  out  DATA_W  captured result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE.
  - All outputs = 0.
  - Skew lines and capture tag pipeline cleared.
  - A reset mid-operation discards all pending results; no done pulse is issued.
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 latches num_vec and w_flat, then goes to LOAD.
  - start is ignored in every other state.
- LOAD: exactly 3 cycles, with sa_p1_en=1 and sa_a*=0.
  - Cycle k (k = 0..2) drives sa_b1..3 = w[k][0..2].
  - Then go to STREAM, or to DRAIN if num_vec = 0.
  - sa_b* = 0 outside LOAD.
- STREAM:
  - act_ready = 1 while accepted count < num_vec.
  - A transfer occurs when act_valid & act_ready.
  - Skew: a transfer at cycle t drives sa_a1 = a1 at t+1, sa_a2 = a2 at t+2, sa_a3 = a3 at t+3 (lane n has n registered delays).
  - Consecutive vectors overlap on the diagonal.
  - A cycle with no transfer injects a zero column (bubble) with no result tag.
  - Go to DRAIN in the cycle after the num_vec-th transfer.
- DRAIN:
  - act_ready = 0.
  - Zeros are shifted into the skew lines.
  - Stays until the skew lines and tag pipeline are empty: at most 2 + RES_LAT cycles after the last transfer.
  - Then go to DONE.
- DONE: done = 1 for one cycle, then return to IDLE; busy drops in IDLE.
- Capture:
  - Each transfer pushes a tag into a RES_LAT-deep shift register aligned with the lane-1 injection.
  - When a tag emerges, res_data <= sa_c and res_valid = 1 for that cycle.
  - There is no backpressure on results: the consumer must accept on every res_valid.
  - Results emerge in vector order; exactly num_vec results per run.
- Width rules:
  - sa_c is passed through unmodified; no arithmetic is performed in the driver.
  - The accepted-count counter is MAX_VEC_W bits and never wraps: num_vec = 2^MAX_VEC_W - 1 is legal.
- Simultaneous events:
  - start while busy is dropped.
  - act_valid in IDLE, LOAD or DRAIN is ignored (act_ready = 0).

Optional Feature:
- Macro SA_DRV_REUSE_W_EN.
- Defined:
  - Adds input port reuse_w (1 bit), sampled with start.
  - reuse_w = 1 skips LOAD (IDLE goes directly to STREAM/DRAIN) and keeps the previously loaded array weights.
  - w_flat is not re-latched.
- Undefined:
  - Port is absent.
  - Every run performs the 3-cycle LOAD.

Decomposition:
- Package sa_drv_pkg holds:
  - the state enum (IDLE, LOAD, STREAM, DRAIN, DONE);
  - SA_N = 3;
  - default DATA_W;
  - the w_flat index helper constant/function.
- Sub-module sa_drv_skew: a one-lane, parameterised-depth (DEPTH, DATA_W) delay line with asynchronous clear. It is instantiated for lanes 1..3 with depths 1..3.
- The tag pipeline reuses sa_drv_skew with DATA_W = 1 and DEPTH = RES_LAT.

Test Plan:
- Preload: weights 1..9, num_vec = 1, start -> sa_p1_en high for 3 cycles with sa_b = (1,2,3), (4,5,6), (7,8,9) in order; sa_a* = 0 during LOAD.
- Skew: vector (1,2,3) accepted at cycle t -> sa_a1 = 1 at t+1, sa_a2 = 2 at t+2, sa_a3 = 3 at t+3, all other sa_a* samples 0; one res_valid at t+1+RES_LAT carrying the sa_c model value; done one cycle after drain.
- Back-to-back: num_vec = 4, act_valid held high -> act_ready high for exactly 4 cycles; lanes show overlapped diagonals; 4 res_valid pulses on consecutive cycles, in order.
- Bubbles and edge cases:
  - act_valid toggling 1,0,1 -> zero column inserted; results spaced by 2 cycles; count still 2.
  - num_vec = 0 -> LOAD, then DONE; no res_valid.
- Reset and ignored inputs:
  - rst asserted mid-STREAM -> all outputs 0 immediately, state IDLE, no done.
  - start during busy ignored.
- SA_DRV_REUSE_W_EN defined: reuse_w = 1 with start -> sa_p1_en never asserted; streaming begins in the cycle after start.
